// File: rtl/score_display.sv
// Four-digit BCD score accumulator with a one-digit-per-cycle adder and a
// free-running, leading-zero-blanked scan of a multiplexed 7-segment display.
module score_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        add_valid,
   input  logic [3:0]  add_val,
   output logic        add_ready,
   output logic [15:0] score,
   output logic [7:0]  seg,
   output logic [3:0]  an
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, SAT} state_t;

   state_t      state_q, state_d;
   logic [15:0] score_q, score_d;
   logic [3:0]  operand_q, operand_d;
   logic        carry_q, carry_d;

   logic [1:0]  dig_sel;
   logic [3:0]  dig_cur;
   logic [3:0]  opnd_cur;
   logic [4:0]  sum;

   always_comb begin
      case (state_q)
         ADD1:    dig_sel = 2'd1;
         ADD2:    dig_sel = 2'd2;
         ADD3:    dig_sel = 2'd3;
         default: dig_sel = 2'd0;
      endcase
      dig_cur  = score_q[{dig_sel, 2'b00} +: 4];
      opnd_cur = (state_q == ADD0) ? operand_q : 4'd0;
      sum      = {1'b0, dig_cur} + {1'b0, opnd_cur} + {4'd0, carry_q};
   end

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      operand_d = operand_q;
      carry_d   = carry_q;
      if (clear) begin
         state_d = IDLE;
         score_d = 16'h0000;
         carry_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (add_valid) begin
                  operand_d = (add_val > 4'd9) ? 4'd9 : add_val;
                  carry_d   = 1'b0;
                  state_d   = ADD0;
               end
            end
            ADD0, ADD1, ADD2, ADD3: begin
               if (sum > 5'd9) begin
                  score_d[{dig_sel, 2'b00} +: 4] = 4'(sum - 5'd10);
                  carry_d = 1'b1;
               end else begin
                  score_d[{dig_sel, 2'b00} +: 4] = sum[3:0];
                  carry_d = 1'b0;
               end
               case (state_q)
                  ADD0:    state_d = ADD1;
                  ADD1:    state_d = ADD2;
                  ADD2:    state_d = ADD3;
                  default: state_d = (sum > 5'd9) ? SAT : IDLE;
               endcase
            end
            SAT: begin
               score_d = 16'h9999;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         score_q   <= 16'h0000;
         operand_q <= 4'd0;
         carry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         operand_q <= operand_d;
         carry_q   <= carry_d;
      end
   end

   assign add_ready = (state_q == IDLE);
   assign score     = score_q;

   // A digit is blank when it and every more significant digit are zero.
   logic [3:0] blank;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_blank
         if (gi == 0) begin : g_units
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = (score_q[15:gi*4] == '0);
         end
      end
   endgenerate

   function automatic logic [7:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   logic [CNT_W-1:0] refresh_cnt_q;
   logic [1:0]       idx_q;
   logic [3:0]       an_q;
   logic [7:0]       seg_q;
   logic [7:0]       seg_d;

   assign seg_d = blank[idx_q] ? 8'hFF : seg_encode(score_q[{idx_q, 2'b00} +: 4]);

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt_q <= '0;
         idx_q         <= 2'd0;
         an_q          <= 4'b1110;
         seg_q         <= 8'hC0;
      end else begin
         if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_q <= '0;
            idx_q         <= idx_q + 2'd1;
         end else begin
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
         end
         an_q  <= ~(4'b0001 << idx_q);
         seg_q <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Randomised and directed stimulus for score_display, checked every cycle
// against a decimal-arithmetic reference model of score, handshake and scan.
module tb_score_display;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        add_valid = 1'b0;
   logic [3:0]  add_val = 4'd0;
   logic        add_ready;
   logic [15:0] score;
   logic [7:0]  seg;
   logic [3:0]  an;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: score as a plain integer, cycles left until idle, edges since reset.
   int m_score = 0;
   int m_busy  = 0;
   int m_scan  = 0;

   score_display #(.REFRESH_DIV(RD)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .add_valid (add_valid),
      .add_val   (add_val),
      .add_ready (add_ready),
      .score     (score),
      .seg       (seg),
      .an        (an)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] disp_seg(input int v, input int pos);
      logic [7:0] tab [10];
      int p;
      tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      p = 1;
      for (int i = 0; i < pos; i++) p = p * 10;
      if (pos > 0 && v < p) return 8'hFF;
      return tab[(v / p) % 10];
   endfunction

   task automatic step();
      int         prev_score;
      bit         prev_known;
      int         idx_b;
      int         v;
      logic [3:0] an_exp;
      prev_score = m_score;
      prev_known = (m_busy == 0);
      @(posedge clk);
      if (reset) begin
         m_score = 0;
         m_busy  = 0;
         m_scan  = 0;
      end else begin
         m_scan++;
         if (clear) begin
            m_score = 0;
            m_busy  = 0;
         end else if (m_busy == 0) begin
            if (add_valid) begin
               v = (add_val > 9) ? 9 : int'(add_val);
               if (m_score + v > 9999) begin
                  m_score = 9999;
                  m_busy  = 5;
               end else begin
                  m_score = m_score + v;
                  m_busy  = 4;
               end
            end
         end else begin
            m_busy--;
         end
      end
      #1;
      check_eq("add_ready", {31'd0, add_ready}, {31'd0, m_busy == 0});
      if (m_busy == 0) check_eq("score", {16'd0, score}, {16'd0, to_bcd(m_score)});
      if (reset) begin
         check_eq("an_rst", {28'd0, an}, 32'h0000_000E);
         check_eq("seg_rst", {24'd0, seg}, 32'h0000_00C0);
      end else begin
         idx_b  = ((m_scan - 1) / RD) % 4;
         an_exp = 4'b0001 << idx_b;
         an_exp = ~an_exp;
         check_eq("an", {28'd0, an}, {28'd0, an_exp});
         if (prev_known) check_eq("seg", {24'd0, seg}, {24'd0, disp_seg(prev_score, idx_b)});
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy != 0 && n < 10) begin
         step();
         n++;
      end
   endtask

   task automatic do_add(input logic [3:0] v);
      int n = 0;
      while (!add_ready && n < 20) begin
         step();
         n++;
      end
      check_eq("ready_wait", {31'd0, add_ready}, 32'd1);
      add_valid = 1'b1;
      add_val   = v;
      step();
      add_valid = 1'b0;
      wait_idle();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int acc;
      int n;

      // 1: reset, then a full scan of 0000
      step();
      step();
      reset = 1'b0;
      idle_cycles(18);

      // 2: 7 + 5 = 0012 and its scan
      do_add(4'd7);
      do_add(4'd5);
      check_eq("score_12", {16'd0, score}, 32'h0000_0012);
      idle_cycles(18);

      // 3: preload 9995 and saturate
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 1110; i++) do_add(4'd9);
      do_add(4'd5);
      check_eq("score_9995", {16'd0, score}, 32'h0000_9995);
      do_add(4'd9);
      check_eq("score_sat", {16'd0, score}, 32'h0000_9999);
      do_add(4'd0);
      do_add(4'd3);
      idle_cycles(18);

      // 4: out-of-range operand, then clear during an add
      clear = 1'b1;
      step();
      clear = 1'b0;
      do_add(4'hF);
      check_eq("score_9", {16'd0, score}, 32'h0000_0009);
      add_valid = 1'b1;
      add_val   = 4'd1;
      step();
      add_valid = 1'b0;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_eq("clear_mid", {16'd0, score}, 32'h0000_0000);

      // clear and add_valid together: the add is dropped
      clear     = 1'b1;
      add_valid = 1'b1;
      add_val   = 4'd6;
      step();
      clear     = 1'b0;
      add_valid = 1'b0;
      step();
      check_eq("clear_wins", {31'd0, add_ready}, 32'd1);

      // 5: add_valid held for 20 cycles
      acc       = 0;
      add_valid = 1'b1;
      add_val   = 4'd1;
      for (int i = 0; i < 20; i++) begin
         if (add_ready) acc++;
         step();
      end
      add_valid = 1'b0;
      wait_idle();
      check_eq("accepts", acc, 32'd4);
      check_eq("score_4", {16'd0, score}, 32'h0000_0004);

      // 6: reset while idx is 2 and an add is running
      n = 0;
      while ((((m_scan) / RD) % 4) != 2 && n < 32) begin
         step();
         n++;
      end
      add_valid = 1'b1;
      add_val   = 4'd8;
      step();
      add_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_an", {28'd0, an}, 32'h0000_000E);
      check_eq("rst_seg", {24'd0, seg}, 32'h0000_00C0);
      check_eq("rst_score", {16'd0, score}, 32'h0000_0000);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         add_valid = 1'($urandom_range(0, 1));
         add_val   = 4'($urandom_range(0, 15));
         clear     = ($urandom_range(0, 39) == 0);
         step();
      end
      add_valid = 1'b0;
      clear     = 1'b0;
      wait_idle();
      idle_cycles(18);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
